// File: rtl/l2_noc2_out_arb_pkg.sv
// Shared L2 NoC2 definitions: header length-field placement, source ids and
// the output arbiter state encoding.
package l2_noc2_out_arb_pkg;

  localparam int unsigned L2_NOC2_LEN_LSB   = 22;
  localparam int unsigned L2_NOC2_LEN_WIDTH = 8;

  localparam logic L2_SRC_PIPE1 = 1'b0;
  localparam logic L2_SRC_PIPE2 = 1'b1;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_e;

endpackage

// File: rtl/l2_noc2_out_reg.sv
// Single-entry registered output stage; a slot is free when empty or draining
// this cycle, which gives full throughput with a registered valid/data.
module l2_noc2_out_reg #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  slot_free_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign slot_free_o = !valid_q || ready_i;

endmodule

// File: rtl/l2_noc2_out_arb.sv
// NoC2 output arbiter: round-robin between the two L2 pipes per message, with
// the grant locked from header through the last payload flit.
module l2_noc2_out_arb
  import l2_noc2_out_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_LSB    = L2_NOC2_LEN_LSB,
  parameter int unsigned LEN_WIDTH  = L2_NOC2_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe1_valid_in,
  input  logic [DATA_WIDTH-1:0] pipe1_data_in,
  output logic                  pipe1_ready_out,
  input  logic                  pipe2_valid_in,
  input  logic [DATA_WIDTH-1:0] pipe2_data_in,
  output logic                  pipe2_ready_out,
  output logic                  noc2_valid_out,
  output logic [DATA_WIDTH-1:0] noc2_data_out,
  input  logic                  noc2_ready_out,
  output logic                  arb_busy,
  output logic                  arb_owner
);

  arb_state_e           state_q, state_d;
  // In IDLE this holds the next-priority source, in LOCK the message owner.
  logic                 owner_q, owner_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;

  logic                  slot_free;
  logic                  grant_src;
  logic                  sel_src;
  logic                  sel_en;
  logic                  accept;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [LEN_WIDTH-1:0]  hdr_len;

  always_comb begin
    if (pipe1_valid_in && pipe2_valid_in) begin
      grant_src = owner_q;
    end else if (pipe2_valid_in) begin
      grant_src = L2_SRC_PIPE2;
    end else begin
      grant_src = L2_SRC_PIPE1;
    end

    sel_src = (state_q == ARB_LOCK) ? owner_q : grant_src;
    sel_en  = rst_n && slot_free &&
              ((state_q == ARB_LOCK) || pipe1_valid_in || pipe2_valid_in);

    pipe1_ready_out = sel_en && (sel_src == L2_SRC_PIPE1);
    pipe2_ready_out = sel_en && (sel_src == L2_SRC_PIPE2);

    accept   = (pipe1_ready_out && pipe1_valid_in) ||
               (pipe2_ready_out && pipe2_valid_in);
    acc_data = (sel_src == L2_SRC_PIPE2) ? pipe2_data_in : pipe1_data_in;
    hdr_len  = acc_data[LEN_LSB +: LEN_WIDTH];
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rem_d   = rem_q;
    if (accept) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (hdr_len == '0) begin
            owner_d = !grant_src;
          end else begin
            state_d = ARB_LOCK;
            owner_d = grant_src;
            rem_d   = hdr_len;
          end
        end
        ARB_LOCK: begin
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = ARB_IDLE;
            owner_d = !owner_q;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= L2_SRC_PIPE1;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rem_q   <= rem_d;
    end
  end

  assign arb_busy  = (state_q == ARB_LOCK);
  assign arb_owner = owner_q;

  l2_noc2_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .data_i     (acc_data),
    .ready_i    (noc2_ready_out),
    .valid_o    (noc2_valid_out),
    .data_o     (noc2_data_out),
    .slot_free_o(slot_free)
  );

endmodule
